// File: rtl/uvmt_cv32e40x_trap_entry_tracker.sv
// Follows each illegal-instruction exception from writeback through trap entry,
// handler execution and mret, reporting latency, a saturating count and error pulses.
module uvmt_cv32e40x_trap_entry_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wb_valid_i,
    input  logic             illegal_insn_i,
    input  logic             wb_mret_i,
    input  logic [31:0]      wb_pc_i,
    input  logic [31:0]      mtvec_i,
    output logic [1:0]       state_o,
    output logic [31:0]      epc_o,
    output logic [CNT_W-1:0] illegal_cnt_o,
    output logic [7:0]       trap_latency_o,
    output logic             err_timeout_o,
    output logic             err_target_o,
    output logic             err_nested_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitTrap = 2'd1,
        StHandler  = 2'd2,
        StInvalid  = 2'd3
    } state_e;

    state_e             r_state, w_state;
    logic [31:0]        r_epc, w_epc;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [7:0]         r_lat, w_lat;
    logic [7:0]         r_wait, w_wait;
    logic               r_err_to, w_err_to;
    logic               r_err_tg, w_err_tg;
    logic               r_err_ne, w_err_ne;
    logic               r_err, w_err;
    logic               w_exc;
    logic               w_at_base;
    logic               w_expire;
    logic [31:0]        w_base;

    assign w_exc     = wb_valid_i && illegal_insn_i;
    assign w_base    = mtvec_i & ~32'h3;
    assign w_at_base = (wb_pc_i == w_base);
    assign w_expire  = (({1'b0, r_wait} + 9'd1) == 9'(TIMEOUT_CYCLES));

    always_comb begin
        w_state  = r_state;
        w_epc    = r_epc;
        w_cnt    = r_cnt;
        w_lat    = r_lat;
        w_wait   = r_wait;
        w_err_to = 1'b0;
        w_err_tg = 1'b0;
        w_err_ne = 1'b0;

        if (w_exc) begin
            w_epc = wb_pc_i;
            if (r_cnt != {CNT_W{1'b1}}) begin
                w_cnt = r_cnt + CNT_W'(1);
            end
        end

        unique case (r_state)
            StIdle: begin
                if (w_exc) begin
                    w_state = StWaitTrap;
                    w_wait  = 8'd0;
                end
            end
            StWaitTrap: begin
                if (wb_valid_i) begin
                    if (w_at_base && !illegal_insn_i) begin
                        w_state = StHandler;
                        w_lat   = r_wait + 8'd1;
                    end else if (w_at_base) begin
                        // The handler's first instruction itself trapped: rearm.
                        w_err_ne = 1'b1;
                        w_wait   = 8'd0;
                    end else begin
                        w_err_tg = 1'b1;
                        w_state  = w_exc ? StWaitTrap : StIdle;
                        w_wait   = 8'd0;
                    end
                end else if (w_expire) begin
                    w_err_to = 1'b1;
                    w_state  = StIdle;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            StHandler: begin
                if (w_exc) begin
                    w_err_ne = 1'b1;
                    w_state  = StWaitTrap;
                    w_wait   = 8'd0;
                end else if (wb_valid_i && wb_mret_i) begin
                    w_state = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase

        w_err = r_err | w_err_to | w_err_tg | w_err_ne;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_epc    <= 32'd0;
            r_cnt    <= '0;
            r_lat    <= 8'd0;
            r_wait   <= 8'd0;
            r_err_to <= 1'b0;
            r_err_tg <= 1'b0;
            r_err_ne <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_epc    <= w_epc;
            r_cnt    <= w_cnt;
            r_lat    <= w_lat;
            r_wait   <= w_wait;
            r_err_to <= w_err_to;
            r_err_tg <= w_err_tg;
            r_err_ne <= w_err_ne;
            r_err    <= w_err;
        end
    end

    assign state_o        = r_state;
    assign epc_o          = r_epc;
    assign illegal_cnt_o  = r_cnt;
    assign trap_latency_o = r_lat;
    assign err_timeout_o  = r_err_to;
    assign err_target_o   = r_err_tg;
    assign err_nested_o   = r_err_ne;
    assign err_o          = r_err;

endmodule

// File: doc/uvmt_cv32e40x_trap_entry_tracker.md
# uvmt_cv32e40x_trap_entry_tracker

Verification-side sequencer that follows each illegal-instruction exception at writeback through trap entry, handler execution and `mret` return. It sits beside the exceptions interface in the cv32e40x UVM testbench and taps the writeback stage. It produces per-exception latency, a running exception count and sticky protocol-error flags for assertions and coverage. It drives no DUT signals.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum accepted cycles from the illegal retire to the first handler retire, legal range 1..255.
- `CNT_W`, default 32: width of the exception counter.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `wb_valid_i`  in  1  instruction retires in writeback this cycle.
- `illegal_insn_i`  in  1  retiring instruction is illegal; qualified by `wb_valid_i`.
- `wb_mret_i`  in  1  retiring instruction is `mret`; qualified by `wb_valid_i`.
- `wb_pc_i`  in  32  PC of the retiring instruction.
- `mtvec_i`  in  32  mtvec CSR value. Direct mode only; the base is `mtvec_i & ~32'h3`.
- `state_o`  out  2  current state: 0 IDLE, 1 WAIT_TRAP, 2 HANDLER.
- `epc_o`  out  32  PC of the most recent illegal instruction.
- `illegal_cnt_o`  out  CNT_W  number of illegal retires; saturating.
- `trap_latency_o`  out  8  latency of the last successful trap entry.
- `err_timeout_o`  out  1  one-cycle pulse.
- `err_target_o`  out  1  one-cycle pulse: first retire after the exception is not at the mtvec base.
- `err_nested_o`  out  1  one-cycle pulse: illegal retire while in the handler or at trap entry.
- `err_o`  out  1  sticky OR of all error pulses.

## Operation
- Event E = `wb_valid_i && illegal_insn_i`. Every E increments `illegal_cnt_o`, saturating at all-ones, and loads `epc_o <= wb_pc_i`, in any state.
- Internal `wait_cnt[7:0]` is cleared whenever WAIT_TRAP is entered.
- **IDLE**
  - On E: go to WAIT_TRAP.
  - Other retires, including `mret`, are ignored.
- **WAIT_TRAP**
  - If `wb_valid_i` and `wb_pc_i == (mtvec_i & ~3)` and not `illegal_insn_i`: go to HANDLER and set `trap_latency_o <= wait_cnt+1`.
  - If `wb_valid_i` at the mtvec base with `illegal_insn_i`: pulse `err_nested_o`, stay in WAIT_TRAP, clear `wait_cnt`. The handler itself trapped.
  - If `wb_valid_i` at any other PC: pulse `err_target_o` and go to IDLE. If that retire is also E, go to WAIT_TRAP instead.
  - If not `wb_valid_i` and `wait_cnt+1 == TIMEOUT_CYCLES`: pulse `err_timeout_o` and go to IDLE.
  - Otherwise `wait_cnt++`.
- **HANDLER**
  - On E: pulse `err_nested_o` and go to WAIT_TRAP.
  - On `wb_valid_i && wb_mret_i` without illegal: go to IDLE.
  - Other retires: stay.
- Priority on a single retire: illegal over `mret`. Both high means E.
- `err_o` is set on any error pulse and is cleared only by reset.
- `mtvec_i` is sampled live every cycle. A change while in WAIT_TRAP takes effect immediately.
- State encoding 3 is unreachable. If entered, go to IDLE.

## Timing
- All outputs are registered and update on the clock edge that samples the triggering inputs. Latency is 1 cycle from input to output.
- Reset values:
  - `state_o` = 0, `epc_o` = 0, `illegal_cnt_o` = 0, `trap_latency_o` = 0.
  - All `err_*` outputs = 0.
  - Internal `wait_cnt` = 0.
- Latency definition: the handler retiring in the cycle immediately after E gives `trap_latency_o` = 1.
- Accepted latencies are 1..TIMEOUT_CYCLES. Timeout fires on the edge where `wait_cnt+1 == TIMEOUT_CYCLES` with no retire. With the default that is 16 cycles after E, so `err_timeout_o` is high in cycle 16.
- Error pulses are high for exactly one cycle. Back-to-back errors produce consecutive pulses.
- Reset asserted mid-sequence returns every output to its reset value immediately, without waiting for a clock edge. After release, the first sampling edge behaves as IDLE.

## Test plan
- **Normal flow.** mtvec=0x100. E at pc 0x80, handler at 0x100 retires 3 cycles later, then `mret`. Required: `state_o` goes 1 then 2 then 0; `trap_latency_o`=3; `epc_o`=0x80; `illegal_cnt_o`=1; `err_o`=0.
- **Timeout.** TIMEOUT_CYCLES=4. E, then no retire. Required: `err_timeout_o` pulses once, exactly 4 cycles after E; `state_o`=0; `err_o` stays 1.
- **Wrong target.** mtvec=0x101, base 0x100. E, next retire at pc 0x104. Required: `err_target_o` pulse; `state_o`=0. Repeat with the next retire at 0x100: HANDLER entered, proving the mode bits are masked.
- **Nested.** In HANDLER, issue E at 0x110. Required: `err_nested_o` pulse; `state_o`=1; `epc_o`=0x110; `illegal_cnt_o`=2. A later handler retire at 0x100 re-enters HANDLER.
- **Priority and saturation.** CNT_W=2. Four E events, the last one with `wb_mret_i`=1. Required: the last E is treated as illegal, not `mret`; `illegal_cnt_o` saturates at 3.
- **Reset mid-WAIT_TRAP.** Assert `rst_ni` low between clock edges while in WAIT_TRAP. Required: all outputs are 0 before the next edge, and no timeout pulse occurs after release.
